imem_loader_arb: RTL and testbench
==================================

IMEM_LOADER_ARB -- requirements
Module: imem_loader_arb

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9, meaning byte-address width of instruction memory.
REQ-002 SHALL have parameter INS_W, default 32, meaning instruction word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a load.
REQ-006 SHALL have port load_len, input, INS_ADDRESS-1, number of words to load, sampled on start.
REQ-007 SHALL have port byte_valid, input, 1, loader byte available.
REQ-008 SHALL have port byte_data, input, 8, loader byte.
REQ-009 SHALL have port byte_ready, output, 1, block accepts byte this cycle.
REQ-010 SHALL have port core_pc, input, INS_ADDRESS, core fetch byte address.
REQ-011 SHALL have port core_inst, output, INS_W, instruction returned to core.
REQ-012 SHALL have port core_hold, output, 1, core must stall PC.
REQ-013 SHALL have ports mem_ra (output, INS_ADDRESS, read address), mem_rd (input, INS_W, read data), mem_we (output, 1, write strobe), mem_wa (output, INS_ADDRESS, write byte address), and mem_wd (output, INS_W, write data).
REQ-014 SHALL have ports busy (output, 1, load in progress), done (output, 1, last load completed), and checksum (output, 32, word sum).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE/DONE + start=1: latch load_len, clear byte/word counters, go LOAD; if load_len=0 go DONE directly.
REQ-017 start while in LOAD or WRITE SHALL be ignored.
REQ-018 byte_ready SHALL be 1 only in LOAD; a byte is accepted when byte_valid & byte_ready.
REQ-019 Bytes SHALL assemble little-endian: first accepted byte to bits 7:0, fourth to 31:24.
REQ-020 On acceptance of the fourth byte the FSM SHALL enter WRITE; in WRITE, mem_we=1 for exactly one cycle, with mem_wa={word_index,2'b00} and mem_wd the assembled word.
REQ-021 After WRITE, word_index SHALL increment; the FSM SHALL go DONE if word_index+1 equals the latched length, else LOAD.
REQ-022 Word index SHALL be INS_ADDRESS-2 bits; load_len of 2**(INS_ADDRESS-2) SHALL fill memory without wrap-around, and larger values SHALL be clamped to that.
REQ-023 busy SHALL be 1 in LOAD and WRITE; done SHALL be 1 in DONE only.
REQ-024 core_hold SHALL equal busy.
REQ-025 mem_ra SHALL equal core_pc at all times (combinational).
REQ-026 core_inst SHALL be 32'h00000013 (NOP) while core_hold=1, else mem_rd (combinational, zero latency).
REQ-027 mem_we SHALL be 0 outside WRITE; mem_wa/mem_wd SHALL hold their last values when not writing.

Reset
REQ-028 reset SHALL force IDLE asynchronously and zero the counters, the assembly register, and the latched length.
REQ-029 After reset, byte_ready, mem_we, busy, done, and core_hold SHALL be 0, mem_wa/mem_wd SHALL be 0, and checksum SHALL be 0.
REQ-030 Reset mid-load SHALL discard the partial word; words already written SHALL remain in memory.

Configuration
REQ-031 With macro IMEM_LOADER_CHECKSUM_EN defined, checksum SHALL be cleared on start and, in each WRITE cycle, increase by mem_wd modulo 2**32.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator SHALL be synthesized.

Verification
REQ-033 Scenario 1: reset, start, load_len=2, bytes 33 70 00 00 93 00 10 00 -> writes 00007033@0x000 and 00100093@0x004, then done=1 and checksum=001070C6 (macro on).
REQ-034 Scenario 2: byte_valid toggling every other cycle during a 1-word load -> exactly 4 bytes accepted, one mem_we pulse, and byte_ready=0 in the WRITE cycle.
REQ-035 Scenario 3: core_pc=0x004 with memory holding 00100093 -> core_inst=00100093 when idle, and 00000013 while busy.
REQ-036 Scenario 4: reset asserted after 2 bytes of the second word -> busy=0 immediately, no further mem_we, and word 0 intact.
REQ-037 Scenario 5: start with load_len=0 -> DONE next cycle with no mem_we; start pulsed during LOAD -> no restart (counters unchanged).
REQ-038 Scenario 6: load_len=128 -> 128 writes, last at 0x1FC, then done=1 with no wrap to 0x000.

Source files
------------

// File: rtl/imem_loader_arb.sv
// Instruction-memory loader: assembles bytes into words, writes them to IMEM and stalls the core meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to build the running word-sum on the checksum port.
module imem_loader_arb #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INS_ADDRESS-2:0] load_len,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  input  logic [INS_ADDRESS-1:0] core_pc,
  output logic [INS_W-1:0]       core_inst,
  output logic                   core_hold,
  output logic [INS_ADDRESS-1:0] mem_ra,
  input  logic [INS_W-1:0]       mem_rd,
  output logic                   mem_we,
  output logic [INS_ADDRESS-1:0] mem_wa,
  output logic [INS_W-1:0]       mem_wd,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            checksum
);

  localparam int IDX_W = INS_ADDRESS - 2;
  localparam int LEN_W = INS_ADDRESS - 1;
  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(2 ** IDX_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [1:0]         r_byte_cnt;
  logic [IDX_W-1:0]   r_word_idx;
  logic [23:0]        r_asm;
  logic [INS_ADDRESS-1:0] r_wa;
  logic [INS_W-1:0]   r_wd;

  logic               w_start_ok;
  logic               w_accept;
  logic               w_last_word;
  logic [LEN_W-1:0]   w_len_clamped;

  assign w_start_ok    = start && (r_state == IDLE || r_state == DONE);
  assign w_accept      = byte_valid && byte_ready;
  assign w_last_word   = (LEN_W'(r_word_idx) + LEN_W'(1)) == r_len;
  assign w_len_clamped = (load_len > MAX_WORDS) ? MAX_WORDS : load_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = (load_len == '0) ? DONE : LOAD;
      LOAD:       if (byte_valid && r_byte_cnt == 2'd3) w_next = WRITE;
      WRITE:      w_next = w_last_word ? DONE : LOAD;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (r_state == LOAD);
    mem_we     = (r_state == WRITE);
    busy       = (r_state == LOAD) || (r_state == WRITE);
    done       = (r_state == DONE);
  end

  // Bytes shift in from the top so the first byte ends up in bits 7:0 of the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_asm      <= '0;
      r_wa       <= '0;
      r_wd       <= '0;
    end else begin
      if (w_start_ok) begin
        r_len      <= w_len_clamped;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
        r_asm      <= '0;
      end
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_asm      <= {byte_data, r_asm[23:8]};
        if (r_byte_cnt == 2'd3) begin
          r_wa <= {r_word_idx, 2'b00};
          r_wd <= INS_W'({byte_data, r_asm});
        end
      end
      if (r_state == WRITE) r_word_idx <= r_word_idx + IDX_W'(1);
    end
  end

  assign mem_wa    = r_wa;
  assign mem_wd    = r_wd;
  assign mem_ra    = core_pc;
  assign core_hold = busy;
  assign core_inst = core_hold ? INS_W'(32'h0000_0013) : mem_rd;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_sum <= '0;
    else if (w_start_ok)    r_sum <= '0;
    else if (r_state == WRITE) r_sum <= r_sum + 32'(r_wd);
  end

  assign checksum = r_sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader_arb.sv
// Self-checking bench for imem_loader_arb: word-level reference model plus directed scenarios.
module tb_imem_loader_arb;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  load_len = 8'd0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic [8:0]  core_pc = 9'd0;
   logic [31:0] core_inst;
   logic        core_hold;
   logic [8:0]  mem_ra;
   logic [31:0] mem_rd;
   logic        mem_we;
   logic [8:0]  mem_wa;
   logic [31:0] mem_wd;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   int checks = 0;
   int errors = 0;
   logic checkOn = 1'b0;

   imem_loader_arb #(.INS_ADDRESS(9), .INS_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .load_len(load_len),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .core_pc(core_pc), .core_inst(core_inst), .core_hold(core_hold),
      .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wa(mem_wa),
      .mem_wd(mem_wd), .busy(busy), .done(done), .checksum(checksum)
   );

   always #5 clk = ~clk;

   // Instruction memory attached to the DUT: combinational read, clocked write.
   logic [31:0] benchMem [0:127];
   assign mem_rd = benchMem[mem_ra[8:2]];
   always @(posedge clk) if (mem_we) benchMem[mem_wa[8:2]] <= mem_wd;

   // Observation counters for the directed literal checks.
   int weCount = 0;
   int acceptCount = 0;
   logic [8:0] lastWeAddr = 9'd0;
   always @(posedge clk) begin
      if (mem_we) begin
         weCount <= weCount + 1;
         lastWeAddr <= mem_wa;
      end
      if (byte_valid && byte_ready) acceptCount <= acceptCount + 1;
   end

   // Reference model: tracks progress of a load in words/bytes and the expected memory image.
   int mLen = 0, mBytes = 0, mWords = 0;
   logic mLoading = 1'b0, mWriting = 1'b0, mDone = 1'b0;
   logic [7:0]  mBuf [0:3];
   logic [31:0] mLastData = 32'd0, mSum = 32'd0;
   logic [8:0]  mLastAddr = 9'd0;
   logic [31:0] modelMem [0:127];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mLen = 0; mBytes = 0; mWords = 0;
         mLoading = 1'b0; mWriting = 1'b0; mDone = 1'b0;
         mLastData = 32'd0; mLastAddr = 9'd0; mSum = 32'd0;
      end else if (mWriting) begin
         modelMem[mLastAddr[8:2]] = mLastData;
         mSum = mSum + mLastData;
         mWords = mWords + 1;
         mWriting = 1'b0;
         if (mWords == mLen) mDone = 1'b1;
         else mLoading = 1'b1;
      end else if (mLoading) begin
         if (byte_valid) begin
            mBuf[mBytes] = byte_data;
            mBytes = mBytes + 1;
            if (mBytes == 4) begin
               mLastData = {mBuf[3], mBuf[2], mBuf[1], mBuf[0]};
               mLastAddr = 9'(mWords * 4);
               mWriting = 1'b1;
               mLoading = 1'b0;
               mBytes = 0;
            end
         end
      end else if (start) begin
         mLen = (load_len > 8'd128) ? 128 : int'(load_len);
         mSum = 32'd0; mBytes = 0; mWords = 0;
         mDone = (mLen == 0);
         mLoading = (mLen != 0);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle the DUT outputs are compared against the model, away from the rising edge.
   always @(negedge clk) begin
      if (checkOn) begin
         logic mBusy;
         logic [31:0] expSum;
         mBusy = mLoading | mWriting;
`ifdef IMEM_LOADER_CHECKSUM_EN
         expSum = mSum;
`else
         expSum = 32'd0;
`endif
         checkOutput("byte_ready", 32'(byte_ready), 32'(mLoading));
         checkOutput("busy", 32'(busy), 32'(mBusy));
         checkOutput("core_hold", 32'(core_hold), 32'(mBusy));
         checkOutput("done", 32'(done), 32'(mDone));
         checkOutput("mem_we", 32'(mem_we), 32'(mWriting));
         checkOutput("mem_wa", 32'(mem_wa), 32'(mLastAddr));
         checkOutput("mem_wd", mem_wd, mLastData);
         checkOutput("mem_ra", 32'(mem_ra), 32'(core_pc));
         checkOutput("core_inst", core_inst, mBusy ? NOP : modelMem[core_pc[8:2]]);
         checkOutput("checksum", checksum, expSum);
      end
   end

   task automatic applyStimulus(input logic s, input logic [7:0] len, input logic v, input logic [7:0] d);
      @(negedge clk);
      #1;
      start = s; load_len = len; byte_valid = v; byte_data = d;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b1, w[8*i +: 8]);
      idleCycles(1);
   endtask

   function automatic logic [31:0] pat(input int i, input logic [7:0] salt);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, b ^ salt, 8'hC3};
   endfunction

   initial begin
      int we0, acc0;
      logic [31:0] w2;
      for (int i = 0; i < 128; i++) begin
         benchMem[i] = 32'd0;
         modelMem[i] = 32'd0;
      end
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      #1 reset = 1'b0;
      checkOn = 1'b1;

      // Reset values
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
      checkOutput("rst_mem_wa", 32'(mem_wa), 32'd0);
      checkOutput("rst_mem_wd", mem_wd, 32'd0);
      checkOutput("rst_checksum", checksum, 32'd0);

      // Scenario 1: two-word load
      applyStimulus(1'b1, 8'd2, 1'b0, 8'd0);
      sendWord(32'h0000_7033);
      sendWord(32'h0010_0093);
      idleCycles(1);
      checkOutput("s1_word0", benchMem[0], 32'h0000_7033);
      checkOutput("s1_word1", benchMem[1], 32'h0010_0093);
      checkOutput("s1_done", 32'(done), 32'd1);
      checkOutput("s1_writes", 32'(weCount), 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
      checkOutput("s1_checksum", checksum, 32'h0010_70C6);
`else
      checkOutput("s1_checksum", checksum, 32'd0);
`endif

      // Scenario 3: core fetch path idle vs busy
      core_pc = 9'h004;
      #1 checkOutput("s3_inst_idle", core_inst, 32'h0010_0093);
      applyStimulus(1'b1, 8'd1, 1'b0, 8'd0);
      idleCycles(1);
      checkOutput("s3_inst_busy", core_inst, NOP);
      sendWord(32'h1122_3344);
      idleCycles(1);
      checkOutput("s3_inst_after", core_inst, 32'h0010_0093);
      checkOutput("s3_word0", benchMem[0], 32'h1122_3344);

      // Scenario 2: byte_valid toggling on a one-word load
      applyStimulus(1'b1, 8'd1, 1'b0, 8'd0);
      we0 = weCount; acc0 = acceptCount;
      w2 = 32'hA1B2_C3D4;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 8'd0, (i % 2) == 0, (i / 2 < 4) ? w2[8*(i/2) +: 8] : 8'hEE);
         if (i == 7) begin
            checkOutput("s2_ready_in_write", 32'(byte_ready), 32'd0);
            checkOutput("s2_we_in_write", 32'(mem_we), 32'd1);
         end
      end
      idleCycles(1);
      checkOutput("s2_accepted", 32'(acceptCount - acc0), 32'd4);
      checkOutput("s2_we_pulses", 32'(weCount - we0), 32'd1);
      checkOutput("s2_word0", benchMem[0], 32'hA1B2_C3D4);

      // Scenario 4: reset in the middle of the second word
      applyStimulus(1'b1, 8'd2, 1'b0, 8'd0);
      sendWord(32'hCAFE_F00D);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h11);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h22);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'h00);
      checkOutput("s4_busy_before", 32'(busy), 32'd1);
      we0 = weCount;
      reset = 1'b1;
      #1 checkOutput("s4_busy_async", 32'(busy), 32'd0);
      checkOutput("s4_hold_async", 32'(core_hold), 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      idleCycles(6);
      checkOutput("s4_no_more_we", 32'(weCount - we0), 32'd0);
      checkOutput("s4_word0", benchMem[0], 32'hCAFE_F00D);

      // Scenario 5: zero-length load, then start pulses during LOAD and WRITE
      we0 = weCount;
      applyStimulus(1'b1, 8'd0, 1'b0, 8'd0);
      idleCycles(1);
      checkOutput("s5_zero_done", 32'(done), 32'd1);
      checkOutput("s5_zero_busy", 32'(busy), 32'd0);
      idleCycles(2);
      checkOutput("s5_zero_no_we", 32'(weCount - we0), 32'd0);
      applyStimulus(1'b1, 8'd3, 1'b0, 8'd0);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h88);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h77);
      applyStimulus(1'b1, 8'd1, 1'b0, 8'd0);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h66);
      applyStimulus(1'b0, 8'd0, 1'b1, 8'h55);
      applyStimulus(1'b1, 8'd1, 1'b0, 8'd0);
      sendWord(32'h0BAD_BEEF);
      sendWord(32'h1357_9BDF);
      idleCycles(1);
      checkOutput("s5_restart_writes", 32'(weCount - we0), 32'd3);
      checkOutput("s5_word0", benchMem[0], 32'h5566_7788);
      checkOutput("s5_word2", benchMem[2], 32'h1357_9BDF);
      checkOutput("s5_done", 32'(done), 32'd1);

      // Scenario 6: full-memory load, then an oversize length that must clamp
      applyStimulus(1'b1, 8'd128, 1'b0, 8'd0);
      we0 = weCount;
      for (int i = 0; i < 128; i++) sendWord(pat(i, 8'h5A));
      idleCycles(1);
      checkOutput("s6_writes", 32'(weCount - we0), 32'd128);
      checkOutput("s6_last_addr", 32'(lastWeAddr), 32'h1FC);
      checkOutput("s6_done", 32'(done), 32'd1);
      checkOutput("s6_word127", benchMem[127], pat(127, 8'h5A));
      checkOutput("s6_word0", benchMem[0], pat(0, 8'h5A));
      applyStimulus(1'b1, 8'd255, 1'b0, 8'd0);
      we0 = weCount;
      for (int i = 0; i < 128; i++) sendWord(pat(i, 8'hA5));
      idleCycles(3);
      checkOutput("s6_clamp_writes", 32'(weCount - we0), 32'd128);
      checkOutput("s6_clamp_done", 32'(done), 32'd1);
      checkOutput("s6_clamp_word0", benchMem[0], pat(0, 8'hA5));
      checkOutput("s6_clamp_last_addr", 32'(lastWeAddr), 32'h1FC);

      checkOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
